// File: rtl/shf_if.sv
// Handshake/data bundle between the LC-3b SHF datapath and shf_unit.
// Optional macro SHF_CC_EN adds the {n,z,p} condition-code bus cc.
interface shf_if #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 4
);
    logic             start;
    logic [1:0]       mode;
    logic [AMT_W-1:0] amount;
    logic [WIDTH-1:0] in;
    logic             ready;
    logic             busy;
    logic             valid;
    logic [WIDTH-1:0] out;
`ifdef SHF_CC_EN
    logic [2:0]       cc;

    modport master (output start, mode, amount, in,
                    input  ready, busy, valid, out, cc);
    modport slave  (input  start, mode, amount, in,
                    output ready, busy, valid, out, cc);
`else
    modport master (output start, mode, amount, in,
                    input  ready, busy, valid, out);
    modport slave  (input  start, mode, amount, in,
                    output ready, busy, valid, out);
`endif
endinterface

// File: rtl/shf_unit.sv
// Multi-cycle LSHF/RSHFL/RSHFA shifter, STEP bits per cycle, start/valid handshake.
// Optional macro SHF_CC_EN registers {n,z,p} of the result on bus.cc.
module shf_unit #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 4,
    parameter int STEP  = 1
) (
    input logic  clk,
    input logic  rst_n,
    shf_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [1:0] MODE_LSHF  = 2'b00;
    localparam logic [1:0] MODE_RSHFL = 2'b01;
    localparam logic [1:0] MODE_RSV   = 2'b10;

    state_t           state;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] out_q;
    logic [AMT_W-1:0] remaining;
    logic [AMT_W-1:0] k;
    logic [1:0]       mode_q;
    logic             sign;
    logic             ready_q;
    logic             busy_q;
    logic             valid_q;

    // Bits shifted this cycle: min(STEP, remaining); the cast only happens when STEP < remaining.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        k = remaining;
        if (32'(remaining) > STEP) k = AMT_W'(STEP);
    end

    always_comb begin
        shifted = work;
        case (mode_q)
            MODE_LSHF:  shifted = work << k;
            MODE_RSHFL: shifted = work >> k;
            default:    shifted = (work >> k) | ({WIDTH{sign}} & ~({WIDTH{1'b1}} >> k));
        endcase
    end

`ifdef SHF_CC_EN
    logic [2:0] cc_q;

    function automatic logic [2:0] nzp(input logic [WIDTH-1:0] v);
        nzp = {v[WIDTH-1], v == '0, !v[WIDTH-1] && (v != '0)};
    endfunction

    assign bus.cc = cc_q;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            out_q     <= '0;
            work      <= '0;
            remaining <= '0;
            mode_q    <= '0;
            sign      <= 1'b0;
`ifdef SHF_CC_EN
            cc_q      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        work      <= bus.in;
                        mode_q    <= bus.mode;
                        remaining <= bus.amount;
                        sign      <= bus.in[WIDTH-1];
                        ready_q   <= 1'b0;
                        if (bus.amount == '0 || bus.mode == MODE_RSV) begin
                            // Pass-through: result is the operand itself.
                            out_q   <= bus.in;
`ifdef SHF_CC_EN
                            cc_q    <= nzp(bus.in);
`endif
                            valid_q <= 1'b1;
                            state   <= DONE;
                        end else begin
                            busy_q  <= 1'b1;
                            state   <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    work      <= shifted;
                    remaining <= remaining - k;
                    if (remaining == k) begin
                        out_q   <= shifted;
`ifdef SHF_CC_EN
                        cc_q    <= nzp(shifted);
`endif
                        busy_q  <= 1'b0;
                        valid_q <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready = ready_q;
    assign bus.busy  = busy_q;
    assign bus.valid = valid_q;
    assign bus.out   = out_q;
endmodule

// File: doc/shf_unit.md
Name: shf_unit

Overview:
- Multi-cycle, parametrised shifter for the LC-3b SHF datapath; it replaces the single-bit, single-direction combinational shift.
- Performs left shift (LSHF), logical right shift (RSHFL) and arithmetic right shift (RSHFA) by a variable amount.
- Shifts STEP bits per cycle under a start/valid handshake.
- Sits between the register-file read port and the writeback mux; the control FSM waits on valid.

Parameters:
- WIDTH, 16, data width in bits.
- AMT_W, 4, shift-amount width; the amount range is 0 to 2^AMT_W-1.
- STEP, 1, maximum bits shifted per cycle; legal range 1 to WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when ready=1.
- mode  input  2  00 LSHF, 01 RSHFL, 11 RSHFA, 10 reserved.
- amount  input  AMT_W  shift amount, captured with start.
- in  input  WIDTH  operand, captured with start.
- ready  output  1  unit idle; start will be accepted.
- busy  output  1  operation in progress.
- valid  output  1  one-cycle pulse; out holds the result.
- out  output  WIDTH  result register, held until the next completion.
- cc  output  3  {n,z,p} of the result; present only with SHF_CC_EN.

Behaviour:
- Reset is asynchronous on rst_n=0:
  - state=IDLE, ready=1, busy=0, valid=0, out=0, cc=3'b000.
  - All internal working and count registers are cleared.
  - A reset during SHIFT or DONE aborts the operation; no valid pulse follows.
- States are IDLE, SHIFT and DONE.
  - ready=(state==IDLE); busy=(state==SHIFT); valid=(state==DONE).
- IDLE:
  - On start=1, capture in into the working register, mode, amount into the remaining count, and sign=in[WIDTH-1].
  - If amount==0 or mode==10, go to DONE. Otherwise go to SHIFT.
- SHIFT, on each edge:
  - k=min(STEP, remaining); shift the working register by k; remaining-=k.
  - LSHF fills zeros at the LSB end. RSHFL fills zeros at the MSB end. RSHFA fills with the captured sign.
  - When remaining reaches 0, load out from the shifted value and go to DONE.
- DONE:
  - valid=1 for exactly one cycle, then IDLE.
  - start is ignored here; the earliest next acceptance is the following cycle.
- For amount==0 or mode==10, out is loaded with the captured in on the IDLE→DONE edge (pass-through).
- Latency from the start-accept edge to the cycle valid is high: 1 + ceil(amount/STEP) cycles.
  - Examples: amount 0 gives 1 cycle; amount 5 with STEP=1 gives 6 cycles; amount 5 with STEP=4 gives 3 cycles.
- amount >= WIDTH is legal and runs the full count:
  - LSHF and RSHFL give 0.
  - RSHFA gives all-sign (0 or all ones).
- start while busy, or in DONE, is dropped silently; in, mode and amount are don't-care outside the accept cycle.
- out changes only on the edge entering DONE and is stable in all other cycles.
- All arithmetic is unsigned on AMT_W bits; remaining never underflows.

Optional Feature:
- SHF_CC_EN:
  - Defined: adds port cc[2:0]={n,z,p}, registered on the same edge as out. n=out[WIDTH-1]; z=(out==0); p=!n&&!z. The control FSM uses cc to set condition codes without a separate compare stage.
  - Undefined: the cc port and its logic are absent; the timing of all other ports is unchanged.

Test Plan:
- Reset mid-shift: start in=16'h0001, mode=00, amount=15, STEP=1; assert rst_n=0 in the 4th SHIFT cycle → outputs go immediately to ready=1, busy=0, valid=0, out=0; no valid pulse after release.
- LSHF: in=16'h00F3, mode=00, amount=4, STEP=1 → busy for 4 cycles; valid in cycle 5 with out=16'h0F30; out stays 16'h0F30 afterwards until the next completion.
- RSHFA: in=16'h8F00, mode=11, amount=8 → out=16'hFF8F, cc=100 (with SHF_CC_EN). Same operand with RSHFL (mode=01) → out=16'h008F, cc=001.
- Boundaries:
  - amount=0, in=16'h1234 → valid in the next cycle, out=16'h1234.
  - mode=10 → pass-through.
  - amount=15 LSHF of 16'hFFFF → 16'h8000.
  - With AMT_W=5, amount=20 RSHFA of 16'h8000 → 16'hFFFF; amount=20 LSHF → 16'h0000, cc=010.
- Handshake: pulse start again during busy and during DONE with different operands → both ignored and the first result is unchanged. Start asserted in the cycle after DONE → accepted.
- STEP=4, in=16'h0001, LSHF amount=13 → 4 SHIFT cycles (4, 4, 4, 1); valid at latency 5; out=16'h2000.
